// File: rtl/fp_alu_pkg.sv
// Shared definitions for the FP add scheduler slice.
//   FP_W          : operand / result width (IEEE-754 single)
//   FP_SIGN       : sign-bit index inside an operand
//   sched_state_t : scheduler FSM encoding
package fp_alu_pkg;

   localparam int FP_W    = 32;
   localparam int FP_SIGN = 31;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_RESP = 2'd2
   } sched_state_t;

endpackage

// File: rtl/AddOp.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even.
// Subnormal results are flushed to signed zero; overflow returns signed infinity.
// Ports:
//   a, b           : operands
//   out            : a + b
//   under_overflow : result overflowed to infinity or underflowed to zero
module AddOp (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] out,
   output logic        under_overflow
);

   logic        a_inf, b_inf, a_nan, b_nan, swap, eff_sub, rup;
   logic [31:0] big, sml;
   logic [7:0]  e_big, e_sml, d;
   logic [26:0] m_big, m_sml, m_sh, mask, norm;
   logic [27:0] sum;
   logic [4:0]  lz;
   logic [9:0]  e_n, e_r;
   logic [23:0] rnd;

   always_comb begin
      a_inf   = (&a[30:23]) & ~(|a[22:0]);
      b_inf   = (&b[30:23]) & ~(|b[22:0]);
      a_nan   = (&a[30:23]) & (|a[22:0]);
      b_nan   = (&b[30:23]) & (|b[22:0]);
      swap    = (b[30:0] > a[30:0]);
      big     = swap ? b : a;
      sml     = swap ? a : b;
      // subnormals use exponent 1 with no hidden bit
      e_big   = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
      e_sml   = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
      m_big   = {|big[30:23], big[22:0], 3'b000};
      m_sml   = {|sml[30:23], sml[22:0], 3'b000};
      d       = e_big - e_sml;
      if (d >= 8'd27) begin
         mask = '0;
         m_sh = {26'd0, |m_sml};
      end else begin
         mask = (27'd1 << d) - 27'd1;
         m_sh = (m_sml >> d) | {26'd0, |(m_sml & mask)};
      end
      eff_sub = big[31] ^ sml[31];
      sum     = eff_sub ? ({1'b0, m_big} - {1'b0, m_sh}) : ({1'b0, m_big} + {1'b0, m_sh});
      lz = 5'd27;
      for (int i = 0; i < 27; i++) begin
         if (sum[i]) lz = 5'(26 - i);
      end
      if (sum[27]) begin
         norm = sum[27:1] | {26'd0, sum[0]};
         e_n  = {2'b00, e_big} + 10'd1;
      end else begin
         norm = sum[26:0] << lz;
         e_n  = {2'b00, e_big} - {5'd0, lz};
      end
      rup = norm[2] & (norm[3] | norm[1] | norm[0]);
      rnd = {1'b0, norm[25:3]} + {23'd0, rup};
      e_r = e_n + {9'd0, rnd[23]};

      out            = '0;
      under_overflow = 1'b0;
      if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) begin
         out = 32'h7FC0_0000;
      end else if (a_inf) begin
         out = a;
      end else if (b_inf) begin
         out = b;
      end else if (!norm[26]) begin
         // exact zero: -0 only when both inputs are negative
         out = {big[31] & sml[31], 31'd0};
      end else if ($signed(e_r) >= 10'sd255) begin
         out            = {big[31], 8'hFF, 23'd0};
         under_overflow = 1'b1;
      end else if ($signed(e_r) < 10'sd1) begin
         out            = {big[31], 31'd0};
         under_overflow = 1'b1;
      end else begin
         out = {big[31], e_r[7:0], rnd[22:0]};
      end
   end

endmodule

// File: rtl/fp_rr_arbiter.sv
// Round-robin grant selection: first valid requester after i_rr_ptr, wrapping.
// Ports:
//   i_req_valid : per-requester valid
//   i_rr_ptr    : last requester served
//   o_grant     : one-hot grant (zero when no request)
//   o_grant_idx : binary index of the grant
//   o_grant_any : any requester granted
module fp_rr_arbiter #(
   parameter  int N_REQ = 2,
   localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] i_req_valid,
   input  logic [ID_W-1:0]  i_rr_ptr,
   output logic [N_REQ-1:0] o_grant,
   output logic [ID_W-1:0]  o_grant_idx,
   output logic             o_grant_any
);

   always_comb begin
      int idx;
      idx         = 0;
      o_grant     = '0;
      o_grant_idx = '0;
      o_grant_any = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(i_rr_ptr) + k) % N_REQ;
         if (!o_grant_any && i_req_valid[idx]) begin
            o_grant_any  = 1'b1;
            o_grant_idx  = ID_W'(idx);
            o_grant[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fp_add_scheduler.sv
// Round-robin scheduler sharing one AddOp among N_REQ requesters.
// Optional feature macro: FP_SCHED_SUB_EN adds req_sub; when set the latched
// B sign is inverted so the result is A - B.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester handshake (ready one-hot, IDLE only)
//   req_a, req_b        : packed operands, requester i at [32*i+:32]
//   req_sub             : per-requester subtract select (FP_SCHED_SUB_EN only)
//   rsp_valid/rsp_ready : response handshake
//   rsp_data, rsp_flag  : registered sum and under/overflow flag
//   rsp_id              : requester owning the response
//   busy                : state is not IDLE
//
// state  | meaning
// S_IDLE | arbitrating, req_ready asserted for the winner
// S_CALC | AddOp evaluating the latched operands
// S_RESP | result presented until rsp_ready
module fp_add_scheduler
   import fp_alu_pkg::*;
#(
   parameter  int N_REQ = 2,
   localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [FP_W*N_REQ-1:0] req_a,
   input  logic [FP_W*N_REQ-1:0] req_b,
`ifdef FP_SCHED_SUB_EN
   input  logic [N_REQ-1:0]      req_sub,
`endif
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [FP_W-1:0]       rsp_data,
   output logic                  rsp_flag,
   output logic [ID_W-1:0]       rsp_id,
   output logic                  busy
);

   sched_state_t    r_state;
   logic [ID_W-1:0] r_rr_ptr, r_id, r_rsp_id;
   logic [FP_W-1:0] r_a, r_b, r_rsp_data;
   logic            r_rsp_valid, r_rsp_flag, r_busy;
   logic [N_REQ-1:0] w_grant;
   logic [ID_W-1:0]  w_grant_idx;
   logic             w_grant_any;
   logic [FP_W-1:0]  w_b_op, w_sum;
   logic             w_uo;

   fp_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .i_req_valid (req_valid),
      .i_rr_ptr    (r_rr_ptr),
      .o_grant     (w_grant),
      .o_grant_idx (w_grant_idx),
      .o_grant_any (w_grant_any)
   );

`ifdef FP_SCHED_SUB_EN
   logic r_sub;
   assign w_b_op = {r_b[FP_SIGN] ^ r_sub, r_b[FP_SIGN-1:0]};
`else
   assign w_b_op = r_b;
`endif

   AddOp u_add (
      .a              (r_a),
      .b              (w_b_op),
      .out            (w_sum),
      .under_overflow (w_uo)
   );

   assign req_ready = (r_state == S_IDLE) ? w_grant : '0;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign rsp_flag  = r_rsp_flag;
   assign rsp_id    = r_rsp_id;
   assign busy      = r_busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_rr_ptr    <= ID_W'(N_REQ - 1);
         r_id        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_flag  <= 1'b0;
         r_rsp_id    <= '0;
         r_busy      <= 1'b0;
`ifdef FP_SCHED_SUB_EN
         r_sub       <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant_any) begin
                  r_a     <= req_a[FP_W*w_grant_idx +: FP_W];
                  r_b     <= req_b[FP_W*w_grant_idx +: FP_W];
                  r_id    <= w_grant_idx;
`ifdef FP_SCHED_SUB_EN
                  r_sub   <= req_sub[w_grant_idx];
`endif
                  r_state <= S_CALC;
                  r_busy  <= 1'b1;
               end
            end
            S_CALC: begin
               r_rsp_data  <= w_sum;
               r_rsp_flag  <= w_uo;
               r_rsp_id    <= r_id;
               r_rsp_valid <= 1'b1;
               r_state     <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_rr_ptr    <= r_id;
                  r_state     <= S_IDLE;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_add_scheduler.sv
module tb_fp_add_scheduler;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid, req_ready;
   logic [32*N-1:0] req_a, req_b;
`ifdef FP_SCHED_SUB_EN
   logic [N-1:0]   req_sub;
`endif
   logic           rsp_valid, rsp_ready, rsp_flag, busy;
   logic [31:0]    rsp_data;
   logic [1:0]     rsp_id;

   always #5 clk = ~clk;

   fp_add_scheduler #(.N_REQ(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
`ifdef FP_SCHED_SUB_EN
      .req_sub   (req_sub),
`endif
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_flag  (rsp_flag),
      .rsp_id    (rsp_id),
      .busy      (busy)
   );

   int vectors = 0;
   int errors  = 0;
   logic chk_en = 1'b0;
   logic keep_all = 1'b0;

   // requester side: pending operand pairs
   logic        p_valid [N];
   logic [31:0] p_a [N];
   logic [31:0] p_b [N];
   logic        p_sub [N];

   // reference model of the scheduler as seen from outside
   int          m_phase;   // 0 waiting, 1 computing, 2 presenting
   int          m_last, m_cur, m_id, m_gnt;
   logic        m_rsp_valid, m_flag;
   logic [31:0] m_data;
   logic [32:0] m_res;

   // observed completed handshakes
   int          obs_id [$];
   logic [31:0] obs_data [$];
   logic        obs_flag [$];

   task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic real f2r(input logic [31:0] x);
      real v;
      int  e;
      e = int'(x[30:23]);
      if (e == 0) v = real'(x[22:0]) * (2.0 ** (-149.0));
      else        v = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** real'(e - 127));
      return x[31] ? -v : v;
   endfunction

   // exact sum in double, then round-to-nearest-even into single
   function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b);
      real         r;
      logic [63:0] bits;
      logic [22:0] keep;
      logic [28:0] rem;
      logic [24:0] m;
      logic        up;
      int          se;
      r = f2r(a) + f2r(b);
      if (r == 0.0) return {1'b0, a[31] & b[31], 31'd0};
      bits = $realtobits(r);
      se   = int'(bits[62:52]) - 1023 + 127;
      keep = bits[51:29];
      rem  = bits[28:0];
      up   = (rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && keep[0]);
      m    = {1'b0, 1'b1, keep} + {24'd0, up};
      if (m[24]) begin se = se + 1; keep = 23'd0; end
      else keep = m[22:0];
      if (se >= 255) return {1'b1, bits[63], 8'hFF, 23'd0};
      if (se < 1)    return {1'b1, bits[63], 31'd0};
      return {1'b0, bits[63], se[7:0], keep};
   endfunction

   function automatic logic [31:0] rand_fp();
      logic [7:0] e;
      e = 8'($urandom_range(120, 135));
      return {1'($urandom_range(0, 1)), e, 23'($urandom)};
   endfunction

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req_valid[i]        = p_valid[i];
         req_a[32*i +: 32]   = p_a[i];
         req_b[32*i +: 32]   = p_b[i];
`ifdef FP_SCHED_SUB_EN
         req_sub[i]          = p_sub[i];
`endif
      end
   endtask

   task automatic model_edge();
      logic [31:0] bb;
      if (rst) begin
         m_phase = 0; m_last = N - 1; m_rsp_valid = 1'b0;
         m_data = '0; m_flag = 1'b0; m_id = 0;
         return;
      end
      case (m_phase)
         0: if (m_gnt >= 0) begin
               bb      = p_b[m_gnt] ^ {p_sub[m_gnt], 31'd0};
               m_res   = ref_add(p_a[m_gnt], bb);
               m_cur   = m_gnt;
               p_valid[m_gnt] = 1'b0;
               m_phase = 1;
            end
         1: begin
               m_rsp_valid = 1'b1;
               m_data      = m_res[31:0];
               m_flag      = m_res[32];
               m_id        = m_cur;
               m_phase     = 2;
            end
         default: if (rsp_ready) begin
               m_rsp_valid = 1'b0;
               m_last      = m_cur;
               m_phase     = 0;
            end
      endcase
   endtask

   // one clock: drive at negedge, check ready, model the edge, check outputs
   task automatic step();
      logic [N-1:0] exp_ready;
      drive();
      #1;
      m_gnt = -1;
      for (int k = 1; k <= N; k++) begin
         if (m_gnt < 0 && p_valid[(m_last + k) % N]) m_gnt = (m_last + k) % N;
      end
      exp_ready = '0;
      if (m_phase == 0 && m_gnt >= 0) exp_ready[m_gnt] = 1'b1;
      if (chk_en) chk("req_ready", 33'(req_ready), 33'(exp_ready));
      if (rsp_valid && rsp_ready && !rst) begin
         obs_id.push_back(int'(rsp_id));
         obs_data.push_back(rsp_data);
         obs_flag.push_back(rsp_flag);
      end
      model_edge();
      if (keep_all) begin
         for (int i = 0; i < N; i++) begin
            if (!p_valid[i]) begin p_valid[i] = 1'b1; p_a[i] = rand_fp(); p_b[i] = rand_fp(); end
         end
      end
      @(negedge clk);
      if (chk_en) begin
         chk("rsp_valid", 33'(rsp_valid), 33'(m_rsp_valid));
         chk("busy",      33'(busy),      33'(m_phase != 0));
         chk("rsp_data",  33'(rsp_data),  33'(m_data));
         chk("rsp_flag",  33'(rsp_flag),  33'(m_flag));
         chk("rsp_id",    33'(rsp_id),    33'(m_id));
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chk_obs(input string nm, input int k, input int id, input logic [31:0] d, input logic f);
      if (obs_id.size() <= k) chk({nm, "_count"}, 33'(obs_id.size()), 33'(k + 1));
      else begin
         chk({nm, "_id"},   33'(obs_id[k]),   33'(id));
         chk({nm, "_data"}, 33'(obs_data[k]), 33'(d));
         chk({nm, "_flag"}, 33'(obs_flag[k]), 33'(f));
      end
   endtask

   task automatic req(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
      p_valid[i] = 1'b1; p_a[i] = a; p_b[i] = b; p_sub[i] = s;
   endtask

   task automatic clear_obs();
      obs_id.delete(); obs_data.delete(); obs_flag.delete();
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin p_valid[i] = 1'b0; p_a[i] = '0; p_b[i] = '0; p_sub[i] = 1'b0; end
      req_valid = '0; req_a = '0; req_b = '0;
`ifdef FP_SCHED_SUB_EN
      req_sub = '0;
`endif
      rsp_ready = 1'b0; rst = 1'b1;
      m_phase = 0; m_last = N - 1; m_rsp_valid = 1'b0; m_data = '0; m_flag = 1'b0;
      m_id = 0; m_cur = 0; m_gnt = -1; m_res = '0;

      // pin the reference model with hand-computed sums
      chk("model_12.5+5.25",  ref_add(32'h41480000, 32'h40A80000), {1'b0, 32'h418E0000});
      chk("model_sum",        ref_add(32'h41A20000, 32'h414C0000), {1'b0, 32'h42040000});
      chk("model_diff",       ref_add(32'h41A20000, 32'hC14C0000), {1'b0, 32'h40F00000});
      chk("model_neg",        ref_add(32'hC1A20000, 32'h414C0000), {1'b0, 32'hC0F00000});
      chk("model_round",      ref_add(32'h4504D8B4, 32'h461B13F8), {1'b0, 32'h463C4A25});
      chk("model_ovf",        ref_add(32'h7F7FFFFF, 32'h7F7FFFFF), {1'b1, 32'h7F800000});

      @(negedge clk);
      step();
      chk_en = 1'b1;
      step();
      rst = 1'b0;
      chk("reset_valid", 33'(rsp_valid), 33'd0);
      chk("reset_busy",  33'(busy),      33'd0);
      chk("reset_data",  33'(rsp_data),  33'd0);
      chk("reset_id",    33'(rsp_id),    33'd0);

      // single request
      clear_obs();
      req(0, 32'h41480000, 32'h40A80000, 1'b0);
      rsp_ready = 1'b1;
      step();
      chk("t1_busy_after_accept", 33'(busy), 33'd1);
      step();
      chk("t1_valid", 33'(rsp_valid), 33'd1);
      chk("t1_data",  33'(rsp_data),  33'h418E0000);
      run(2);
      chk_obs("t1", 0, 0, 32'h418E0000, 1'b0);

      // contention from a fresh reset
      rst = 1'b1; step(); rst = 1'b0;
      clear_obs();
      req(0, 32'h41A20000, 32'h414C0000, 1'b0);
      req(1, 32'h41A20000, 32'hC14C0000, 1'b0);
      run(8);
      chk_obs("t2_first",  0, 0, 32'h42040000, 1'b0);
      chk_obs("t2_second", 1, 1, 32'h40F00000, 1'b0);

      // backpressure with a competing request waiting
      clear_obs();
      rsp_ready = 1'b0;
      req(0, 32'hC1A20000, 32'h414C0000, 1'b0);
      step();
      req(2, 32'h40000000, 32'h40000000, 1'b0);
      step();
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t3_hold_data", 33'(rsp_data),  33'hC0F00000);
         chk("t3_ready",     33'(req_ready), 33'd0);
         chk("t3_busy",      33'(busy),      33'd1);
      end
      rsp_ready = 1'b1;
      step();
      chk("t3_released", 33'(rsp_valid), 33'd0);
      run(4);
      chk_obs("t3_bp",    0, 0, 32'hC0F00000, 1'b0);
      chk_obs("t3_after", 1, 2, 32'h40800000, 1'b0);

      // reset while computing
      clear_obs();
      req(3, 32'h3F800000, 32'h3F800000, 1'b0);
      step();
      rst = 1'b1; step(); rst = 1'b0;
      chk("t4_valid", 33'(rsp_valid), 33'd0);
      chk("t4_busy",  33'(busy),      33'd0);
      req(0, 32'h4504D8B4, 32'h461B13F8, 1'b0);
      run(4);
      chk_obs("t4_retry", 0, 0, 32'h463C4A25, 1'b0);
      chk("t4_nodrop", 33'(obs_id.size()), 33'd1);

      // overflow flag
      clear_obs();
      req(2, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0);
      run(4);
      chk_obs("t_ovf", 0, 2, 32'h7F800000, 1'b1);

      // fairness: all requesters continuously valid
      rst = 1'b1; step(); rst = 1'b0;
      clear_obs();
      keep_all = 1'b1;
      run(26);
      keep_all = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (obs_id.size() > k) chk("t5_order", 33'(obs_id[k]), 33'(k % N));
         else chk("t5_count", 33'(obs_id.size()), 33'd8);
      end
      for (int i = 0; i < N; i++) p_valid[i] = 1'b0;
      run(4);

`ifdef FP_SCHED_SUB_EN
      clear_obs();
      req(1, 32'h41A20000, 32'h414C0000, 1'b1);
      run(4);
      chk_obs("t6_sub", 0, 1, 32'h40F00000, 1'b0);
`endif

      // randomized traffic
      for (int n = 0; n < 2000; n++) begin
         for (int i = 0; i < N; i++) begin
            if (!p_valid[i] && $urandom_range(0, 2) == 0) begin
`ifdef FP_SCHED_SUB_EN
               req(i, rand_fp(), rand_fp(), 1'($urandom_range(0, 1)));
`else
               req(i, rand_fp(), rand_fp(), 1'b0);
`endif
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 199) == 0);
         step();
      end
      rst = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
